// File: rtl/serial_shift_unit.sv
// rtl/serial_shift_unit.sv - multi-cycle left/right shifter, one bit position per clock
module serial_shift_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             in_rot,
    input  logic [CNT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   data_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               dir_q;
    logic               rot_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    // Fill bit is zero for logical shifts, the bit leaving the far end for rotates.
    always_comb begin
        data_d = data_q;
        if (dir_q) begin
            data_d = {(rot_q ? data_q[0] : 1'b0), data_q[WIDTH-1:1]};
        end else begin
            data_d = {data_q[WIDTH-2:0], (rot_q ? data_q[WIDTH-1] : 1'b0)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            rot_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        cnt_q      <= in_amt;
                        dir_q      <= in_dir;
                        rot_q      <= in_rot;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (in_amt == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_serial_shift_unit.sv
// tb/tb_serial_shift_unit.sv - randomized self-checking bench for serial_shift_unit
module tb_serial_shift_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_dir;
    logic        in_rot;
    logic [4:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    serial_shift_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_rot    (in_rot),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] d, input logic dir,
                                          input logic rot, input int amt);
        logic [63:0] dd;
        logic [63:0] t;
        int k;
        k  = amt % 32;
        dd = {d, d};
        if (!rot) return dir ? (d >> amt) : (d << amt);
        if (dir) begin
            t = dd >> k;
            return t[31:0];
        end
        t = dd << k;
        return t[63:32];
    endfunction

    task automatic do_req(input logic [31:0] d, input logic dir, input logic rot,
                          input logic [4:0] amt, input bit scramble,
                          output logic [31:0] got, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        in_data  = d;
        in_dir   = dir;
        in_rot   = rot;
        in_amt   = amt;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (scramble) begin
                in_dir  = 1'($urandom);
                in_amt  = 5'($urandom);
                in_data = $urandom;
                in_rot  = 1'($urandom);
            end
            @(posedge clk); #1; lat++;
        end
        got = out_data;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_dir = 1'b0; in_rot = 1'b0; in_amt = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: rdy/vld/busy=%b data=%h required 100 data=0",
                     {in_ready, out_valid, busy}, out_data);
        end
    endtask

    task automatic test_directed();
        logic [31:0] d [4] = '{32'h0000_00F1, 32'h8000_0001, 32'h0000_0001, 32'hFFFF_FFFF};
        logic        dr[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        rt[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [4:0]  am[4] = '{5'd4, 5'd1, 5'd31, 5'd31};
        logic [31:0] ex[4] = '{32'h0000_0F10, 32'hC000_0000, 32'h8000_0000, 32'h0000_0001};
        logic [31:0] got;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_req(d[i], dr[i], rt[i], am[i], (i == 3), got, lat);
            checks++;
            if (got !== ex[i] || lat != int'(am[i])) begin
                errors++;
                $display("FAIL directed_%0d: data=%h lat=%0d required data=%h lat=%0d",
                         i, got, lat, ex[i], am[i]);
            end
            checks++;
            if (in_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL directed_idle_%0d: in_ready=%b busy=%b required 1 0",
                         i, in_ready, busy);
            end
        end
    endtask

    task automatic test_backpressure();
        in_data = 32'hDEAD_BEEF; in_dir = 1'b0; in_rot = 1'b0; in_amt = 5'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL amt0_latency: out_valid=%b required 1", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL backpressure_%0d: vld=%b rdy=%b data=%h required 1 0 deadbeef",
                         i, out_valid, in_ready, out_data);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: rdy=%b vld=%b busy=%b required 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        int lat;
        int seen;
        seen = 0;
        in_data = $urandom; in_dir = 1'b0; in_rot = 1'b1; in_amt = 5'd20;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_data !== 32'h0 || seen != 0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b vld=%b rdy=%b data=%h seen=%0d required 0 0 1 0 0",
                     busy, out_valid, in_ready, out_data, seen);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_lost: out_valid seen %0d times required 0", seen);
        end
        do_req(32'h1, 1'b0, 1'b0, 5'd2, 1'b0, got, lat);
        checks++;
        if (got !== 32'h4 || lat != 2) begin
            errors++;
            $display("FAIL reset_mid_after: data=%h lat=%0d required 00000004 lat=2", got, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, got, ex;
        logic dir, rot;
        logic [4:0] amt;
        int lat;
        for (int i = 0; i < 24; i++) begin
            d = $urandom; dir = 1'($urandom); rot = 1'($urandom);
            amt = (i < 2) ? 5'(31 * i) : 5'($urandom);
            ex = model(d, dir, rot, int'(amt));
            do_req(d, dir, rot, amt, 1'($urandom), got, lat);
            checks++;
            if (got !== ex || lat != int'(amt)) begin
                errors++;
                $display("FAIL random_%0d: d=%h dir=%b rot=%b amt=%0d got=%h lat=%0d required %h lat=%0d",
                         i, d, dir, rot, amt, got, lat, ex, amt);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] d [5];
        logic        dr[5];
        logic        rt[5];
        logic [4:0]  am[5];
        int idx, results, cyc, last_acc, prev_amt;
        logic take;
        for (int i = 0; i < 5; i++) begin
            d[i] = $urandom; dr[i] = 1'($urandom); rt[i] = 1'($urandom);
            am[i] = (i == 0) ? 5'd0 : 5'($urandom_range(0, 9));
        end
        idx = 0; results = 0; cyc = 0; last_acc = -1; prev_amt = 0;
        out_ready = 1'b1;
        in_data = d[0]; in_dir = dr[0]; in_rot = rt[0]; in_amt = am[0]; in_valid = 1'b1;
        while (results < 5 && cyc < 500) begin
            take = in_ready && in_valid;
            @(posedge clk); #1;
            cyc++;
            if (take) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != prev_amt + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing_%0d: %0d cycles required %0d",
                                 idx, cyc - last_acc, prev_amt + 2);
                    end
                end
                exp_q.push_back(model(d[idx], dr[idx], rt[idx], int'(am[idx])));
                last_acc = cyc; prev_amt = int'(am[idx]);
                idx++;
                if (idx < 5) begin
                    in_data = d[idx]; in_dir = dr[idx]; in_rot = rt[idx]; in_amt = am[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL b2b_data_%0d: data=%h required %h", results, out_data,
                             (exp_q.size() != 0) ? exp_q[0] : 32'h0);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                results++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (results != 5) begin
            errors++;
            $display("FAIL b2b_timeout: %0d results required 5", results);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
